// File: rtl/key_schedule_seq_192_if.sv
// Handshake, status and round-key read port of the AES-192 key-schedule block.
// The slave modport is the key-schedule side; master is the cipher/host side.
interface key_schedule_seq_192_if;
  logic         key_valid;
  logic         key_ready;
  logic [191:0] user_key;
  logic         busy;
  logic         done;
  logic         keys_valid;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;

  modport slave (
    input  key_valid, user_key, rd_idx,
    output key_ready, busy, done, keys_valid, rd_key
  );

  modport master (
    output key_valid, user_key, rd_idx,
    input  key_ready, busy, done, keys_valid, rd_key
  );
endinterface

// File: rtl/key_schedule_seq_192.sv
// Sequential AES-192 key schedule: one shared round expander stepped 8 times,
// 54-word register bank, combinational indexed read of the 13 round keys.
module expand_single_round (
  input  logic [191:0] before_ex,
  input  logic [3:0]   round_no,
  output logic [191:0] after_ex
);
  logic [31:0] w [0:11];
  logic [31:0] temp;
  logic [7:0]  rcon;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box = affine(a^254); a^254 built as a^2 * a^4 * ... * a^128 (0 maps to 0).
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] v);
    return {sbox(v[31:24]), sbox(v[23:16]), sbox(v[15:8]), sbox(v[7:0])};
  endfunction

  always_comb begin
    rcon = 8'(8'h01 << (round_no - 4'd1));
    for (int j = 0; j < 6; j++) w[j] = before_ex[191-32*j -: 32];
    temp = sub_word({w[5][23:0], w[5][31:24]}) ^ {rcon, 24'h0};
    w[6] = w[0] ^ temp;
    for (int j = 7; j < 12; j++) w[j] = w[j-6] ^ w[j-1];
    for (int j = 0; j < 6; j++) after_ex[191-32*j -: 32] = w[j+6];
  end
endmodule

module key_schedule_seq_192 (
  input  logic                  clk,
  input  logic                  rst_n,
  key_schedule_seq_192_if.slave bus
);
  localparam int NUM_EXP = 8;
  localparam int NUM_RK  = 13;
  localparam int NUM_W   = 54;

  typedef enum logic {S_IDLE = 1'b0, S_EXPAND = 1'b1} state_t;

  state_t       state_q, state_d;
  logic [3:0]   k_q, k_d;
  logic         done_q, done_d;
  logic         keys_valid_q, keys_valid_d;
  logic [31:0]  w_q [0:NUM_W-1];
  logic [31:0]  w_d [0:NUM_W-1];
  logic [191:0] before_ex, after_ex;
  logic [5:0]   src_base, dst_base, rd_base;
  logic         last_round;

  assign last_round = (k_q == 4'(NUM_EXP));

  // Round k reads w(6k-6..6k-1) and produces w(6k..6k+5).
  always_comb begin
    src_base = (k_q == 4'd0) ? 6'd0 : 6'((int'(k_q) - 1) * 6);
    dst_base = src_base + 6'd6;
    for (int j = 0; j < 6; j++) before_ex[191-32*j -: 32] = w_q[src_base + 6'(j)];
  end

  expand_single_round u_round (
    .before_ex (before_ex),
    .round_no  (k_q),
    .after_ex  (after_ex)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.key_valid) state_d = S_EXPAND;
      S_EXPAND: if (last_round)    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    w_d          = w_q;
    k_d          = k_q;
    done_d       = 1'b0;
    keys_valid_d = keys_valid_q;
    if (state_q == S_IDLE) begin
      if (bus.key_valid) begin
        for (int j = 0; j < 6; j++) w_d[j] = bus.user_key[191-32*j -: 32];
        k_d          = 4'd1;
        keys_valid_d = 1'b0;
      end
    end else begin
      for (int j = 0; j < 6; j++) w_d[dst_base + 6'(j)] = after_ex[191-32*j -: 32];
      if (last_round) begin
        done_d       = 1'b1;
        keys_valid_d = 1'b1;
      end else begin
        k_d = k_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k_q          <= 4'd0;
      done_q       <= 1'b0;
      keys_valid_q <= 1'b0;
      for (int i = 0; i < NUM_W; i++) w_q[i] <= 32'h0;
    end else begin
      k_q          <= k_d;
      done_q       <= done_d;
      keys_valid_q <= keys_valid_d;
      w_q          <= w_d;
    end
  end

  // Status decodes from registered state only; the read port is gated by keys_valid.
  always_comb begin
    bus.key_ready  = (state_q == S_IDLE);
    bus.busy       = (state_q == S_EXPAND);
    bus.done       = done_q;
    bus.keys_valid = keys_valid_q;
    rd_base        = {bus.rd_idx, 2'b00};
    bus.rd_key     = 128'h0;
    if (keys_valid_q && (bus.rd_idx < 4'(NUM_RK))) begin
      bus.rd_key = {w_q[rd_base], w_q[rd_base + 6'd1], w_q[rd_base + 6'd2], w_q[rd_base + 6'd3]};
    end
  end
endmodule

// File: tb/tb_key_schedule_seq_192.sv
// Bench for key_schedule_seq_192: randomized and FIPS-197 keys checked against a
// word-level AES-192 key-expansion model with an independently generated S-box.
module tb_key_schedule_seq_192;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  key_schedule_seq_192_if bus();

  key_schedule_seq_192 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  localparam logic [191:0] KEY_A2 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;

  logic [7:0]  sbox_t [0:255];
  logic [31:0] ref_w  [0:51];

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] t;
    t = {v, v} << n;
    return t[15:8];
  endfunction

  // Walk the multiplicative group with generator 3 and its inverse in lockstep.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  task automatic ref_expand(input logic [191:0] key);
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 6; i++) ref_w[i] = key[191-32*i -: 32];
    for (int i = 6; i < 52; i++) begin
      t = ref_w[i-1];
      if (i % 6 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t = t ^ {rcon, 24'h0};
        rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end
      ref_w[i] = ref_w[i-6] ^ t;
    end
  endtask

  function automatic logic [127:0] ref_rk(input int i);
    return {ref_w[4*i], ref_w[4*i+1], ref_w[4*i+2], ref_w[4*i+3]};
  endfunction

  // Present a key for one edge, then count falling edges until done (-1 on timeout).
  task automatic run_key(input logic [191:0] key, output int cycles);
    @(negedge clk);
    bus.user_key  = key;
    bus.key_valid = 1'b1;
    @(negedge clk);
    bus.key_valid = 1'b0;
    cycles = -1;
    for (int c = 1; c <= 20; c++) begin
      if (bus.done === 1'b1) begin
        cycles = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.key_ready !== 1'b1)  begin errors++; $display("FAIL reset_key_ready: got %b expected 1", bus.key_ready); end
    checks++; if (bus.busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0)       begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.keys_valid !== 1'b0) begin errors++; $display("FAIL reset_keys_valid: got %b expected 0", bus.keys_valid); end
    for (int i = 0; i < 16; i++) begin
      bus.rd_idx = 4'(i);
      #1;
      checks++;
      if (bus.rd_key !== 128'h0) begin errors++; $display("FAIL reset_rd_key[%0d]: got %h expected 0", i, bus.rd_key); end
    end
  endtask

  task automatic test_fips();
    int cyc;
    ref_expand(KEY_A2);
    run_key(KEY_A2, cyc);
    checks++; if (cyc != 9) begin errors++; $display("FAIL fips_latency: got %0d expected 9", cyc); end
    checks++; if (bus.keys_valid !== 1'b1) begin errors++; $display("FAIL fips_keys_valid: got %b expected 1", bus.keys_valid); end
    checks++; if (bus.key_ready !== 1'b1)  begin errors++; $display("FAIL fips_key_ready: got %b expected 1", bus.key_ready); end
    bus.rd_idx = 4'd0; #1;
    checks++; if (bus.rd_key !== 128'h8e73b0f7da0e6452c810f32b809079e5) begin errors++; $display("FAIL fips_rk0: got %h", bus.rd_key); end
    bus.rd_idx = 4'd1; #1;
    checks++; if (bus.rd_key !== 128'h62f8ead2522c6b7bfe0c91f72402f5a5) begin errors++; $display("FAIL fips_rk1: got %h", bus.rd_key); end
    bus.rd_idx = 4'd12; #1;
    checks++; if (bus.rd_key !== 128'he98ba06f448c773c8ecc720401002202) begin errors++; $display("FAIL fips_rk12: got %h", bus.rd_key); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL fips_done_single: got %b expected 0", bus.done); end
  endtask

  task automatic test_sweep();
    logic [127:0] exp_k;
    ref_expand(KEY_A2);
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      bus.rd_idx = 4'(i);
      #1;
      exp_k = (i < 13) ? ref_rk(i) : 128'h0;
      checks++;
      if (bus.rd_key !== exp_k) begin errors++; $display("FAIL sweep_rk[%0d]: got %h expected %h", i, bus.rd_key, exp_k); end
    end
  endtask

  task automatic test_back_to_back();
    logic exp_pulse;
    ref_expand(KEY_A2);
    @(negedge clk);
    bus.user_key  = KEY_A2;
    bus.key_valid = 1'b1;
    for (int i = 1; i <= 27; i++) begin
      @(negedge clk);
      exp_pulse = (i % 9 == 0);
      checks++; if (bus.key_ready !== exp_pulse) begin errors++; $display("FAIL b2b_key_ready@%0d: got %b expected %b", i, bus.key_ready, exp_pulse); end
      checks++; if (bus.done !== exp_pulse)      begin errors++; $display("FAIL b2b_done@%0d: got %b expected %b", i, bus.done, exp_pulse); end
      if (exp_pulse) begin
        bus.rd_idx = 4'd12;
        #1;
        checks++; if (bus.rd_key !== ref_rk(12)) begin errors++; $display("FAIL b2b_rk12@%0d: got %h expected %h", i, bus.rd_key, ref_rk(12)); end
      end
      if (i == 27) begin
        bus.key_valid = 1'b0;
      end else if (bus.key_ready === 1'b1) begin
        bus.key_valid = 1'b1;
        bus.user_key  = KEY_A2;
      end else begin
        bus.key_valid = 1'($urandom_range(0, 1));
        bus.user_key  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      end
    end
    for (int i = 0; i < 13; i++) begin
      bus.rd_idx = 4'(i);
      #1;
      checks++;
      if (bus.rd_key !== ref_rk(i)) begin errors++; $display("FAIL b2b_final_rk[%0d]: got %h expected %h", i, bus.rd_key, ref_rk(i)); end
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    int pulses;
    @(negedge clk);
    bus.user_key  = KEY_A2;
    bus.key_valid = 1'b1;
    @(negedge clk);
    bus.key_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (bus.busy !== 1'b0)       begin errors++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.keys_valid !== 1'b0) begin errors++; $display("FAIL midrst_keys_valid: got %b expected 0", bus.keys_valid); end
    checks++; if (bus.key_ready !== 1'b1)  begin errors++; $display("FAIL midrst_key_ready: got %b expected 1", bus.key_ready); end
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.done !== 1'b0) pulses++;
      @(negedge clk);
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses expected 0", pulses); end
    for (int i = 0; i < 16; i++) begin
      bus.rd_idx = 4'(i);
      #1;
      checks++;
      if (bus.rd_key !== 128'h0) begin errors++; $display("FAIL midrst_rd_key[%0d]: got %h expected 0", i, bus.rd_key); end
    end
    ref_expand(KEY_A2);
    run_key(KEY_A2, cyc);
    checks++; if (cyc != 9) begin errors++; $display("FAIL midrst_rerun_latency: got %0d expected 9", cyc); end
    for (int i = 0; i < 13; i++) begin
      bus.rd_idx = 4'(i);
      #1;
      checks++;
      if (bus.rd_key !== ref_rk(i)) begin errors++; $display("FAIL midrst_rerun_rk[%0d]: got %h expected %h", i, bus.rd_key, ref_rk(i)); end
    end
  endtask

  task automatic test_rekey_zero();
    int cyc;
    @(negedge clk);
    bus.user_key  = 192'h0;
    bus.key_valid = 1'b1;
    bus.rd_idx    = 4'd1;
    @(negedge clk);
    bus.key_valid = 1'b0;
    checks++; if (bus.keys_valid !== 1'b0) begin errors++; $display("FAIL rekey_keys_valid_drop: got %b expected 0", bus.keys_valid); end
    checks++; if (bus.busy !== 1'b1)       begin errors++; $display("FAIL rekey_busy: got %b expected 1", bus.busy); end
    #1;
    checks++; if (bus.rd_key !== 128'h0)   begin errors++; $display("FAIL rekey_rd_during_expand: got %h expected 0", bus.rd_key); end
    cyc = -1;
    for (int c = 1; c <= 20; c++) begin
      if (bus.done === 1'b1) begin
        cyc = c;
        break;
      end
      @(negedge clk);
    end
    checks++; if (cyc != 9) begin errors++; $display("FAIL rekey_latency: got %0d expected 9", cyc); end
    #1;
    checks++; if (bus.rd_key !== 128'h00000000000000006263636362636363) begin errors++; $display("FAIL rekey_zero_rk1: got %h", bus.rd_key); end
    ref_expand(192'h0);
    for (int i = 0; i < 13; i++) begin
      bus.rd_idx = 4'(i);
      #1;
      checks++;
      if (bus.rd_key !== ref_rk(i)) begin errors++; $display("FAIL rekey_zero_rk[%0d]: got %h expected %h", i, bus.rd_key, ref_rk(i)); end
    end
  endtask

  task automatic test_random();
    logic [191:0] key;
    int cyc;
    for (int n = 0; n < 4; n++) begin
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      ref_expand(key);
      run_key(key, cyc);
      checks++; if (cyc != 9) begin errors++; $display("FAIL rand%0d_latency: got %0d expected 9", n, cyc); end
      for (int i = 0; i < 13; i++) begin
        bus.rd_idx = 4'(i);
        #1;
        checks++;
        if (bus.rd_key !== ref_rk(i)) begin errors++; $display("FAIL rand%0d_rk[%0d]: got %h expected %h", n, i, bus.rd_key, ref_rk(i)); end
      end
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.key_valid = 1'b0;
    bus.user_key  = 192'h0;
    bus.rd_idx    = 4'd0;
    build_sbox();
    test_reset();
    test_fips();
    test_sweep();
    test_back_to_back();
    test_reset_mid();
    test_rekey_zero();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
